popcount_scheduler: RTL and testbench

Shares one CHUNK_WIDTH-bit ones-counter among NUM_REQ requesters. Each requester submits a DATA_WIDTH-bit operand. The block arbitrates round-robin and counts the operand one chunk per cycle into an accumulator. It returns the total set-bit count tagged with the requester ID. It sits between the requesting units and the population-count datapath.

---
 rtl/popcount_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_popcount_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_scheduler.sv
// -----------------------------------------------------------------------------
// popcount_scheduler
//
// Shares one CHUNK_WIDTH-bit ones-counter among NUM_REQ requesters. A
// round-robin arbiter grants one requester at a time. The granted operand is
// latched and then counted one chunk per cycle into an accumulator. The total
// set-bit count is returned together with the ID of the requester that owns it.
//
// Parameters
//   NUM_REQ      number of requesters (>= 2)
//   DATA_WIDTH   operand width
//   CHUNK_WIDTH  bits counted per cycle; DATA_WIDTH must be a multiple of it
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]             per-requester operand valid
//   req_ready  out  [NUM_REQ]             per-requester grant, one-hot or zero
//   req_data   in   [NUM_REQ*DATA_WIDTH]  operands, requester i at i*DATA_WIDTH
//   rsp_valid  out                        result valid
//   rsp_ready  in                         result accepted
//   rsp_count  out  [clog2(DATA_WIDTH)+1] set-bit count of the granted operand
//   rsp_id     out  [clog2(NUM_REQ)]      requester that owns rsp_count
//   busy       out                        high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module popcount_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(DATA_WIDTH):0]   rsp_count,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic                          busy
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;
  localparam int POP_W      = $clog2(CHUNK_WIDTH) + 1;
  localparam int ID_W       = $clog2(NUM_REQ);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   operand_q, operand_d;
  logic [CNT_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        rsp_count_q, rsp_count_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;

  // ---------------------------------------------------------------------------
  // Round-robin winner: scan upward from rr_ptr_q with wrap-around.
  // rr_ptr_q + k never reaches 2*NUM_REQ, so a single conditional subtract
  // implements the modulo, also for non-power-of-two NUM_REQ.
  // ---------------------------------------------------------------------------
  logic [ID_W:0]           scan_sum;
  logic                    grant_found;
  logic [ID_W-1:0]         grant_idx;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    scan_sum    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[ID_W-1:0];
      end
    end
  end

  // Operand slice of the winner.
  logic [DATA_WIDTH-1:0]   grant_data;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Chunk counter datapath.
  // ---------------------------------------------------------------------------
  function automatic logic [POP_W-1:0] popcount(input logic [CHUNK_WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int b = 0; b < CHUNK_WIDTH; b++) begin
      n = n + POP_W'(v[b]);
    end
    return n;
  endfunction

  logic [CHUNK_WIDTH-1:0]  chunk;
  logic [POP_W-1:0]        chunk_pop;
  logic [CNT_W-1:0]        acc_sum;
  logic                    last_chunk;

  always_comb begin
    chunk = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      if (idx_q == IDX_W'(c)) begin
        chunk = operand_q[c*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  assign chunk_pop  = popcount(chunk);
  // Zero-extended chunk count; CNT_W bits hold DATA_WIDTH without overflow.
  assign acc_sum    = acc_q + CNT_W'(chunk_pop);
  assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register, next-state logic, output logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_found) state_d = COUNT;
      COUNT:   if (last_chunk)  state_d = RESP;
      RESP:    if (rsp_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    // Gating with resetn keeps the combinational grant low while reset is
    // held, even though the FSM already sits in IDLE.
    if (state_q == IDLE && grant_found && resetn) begin
      req_ready[grant_idx] = 1'b1;
    end
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state and registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    operand_d   = operand_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_count_d = rsp_count_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          // req_data is sampled only here; later changes are ignored.
          operand_d = grant_data;
          rsp_id_d  = grant_idx;
          acc_d     = '0;
          idx_d     = '0;
          rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      COUNT: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (last_chunk) begin
          rsp_count_d = acc_sum;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      operand_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      rsp_count_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_count_q <= rsp_count_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_count = rsp_count_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_popcount_scheduler.sv
// -----------------------------------------------------------------------------
// tb_popcount_scheduler
//
// Directed scenarios plus a randomized run for popcount_scheduler. Expected
// grants come from a round-robin model (scan from a model pointer), expected
// counts from $countones of the operand the bench drove at the grant cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_popcount_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int DATA_WIDTH  = 64;
  localparam int CHUNK_WIDTH = 16;
  localparam int NUM_CHUNKS  = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W       = $clog2(DATA_WIDTH) + 1;
  localparam int ID_W        = $clog2(NUM_REQ);
  localparam int LAT         = 1 + NUM_CHUNKS;

  logic                          clk = 1'b0;
  logic                          resetn = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic                          rsp_valid;
  logic                          rsp_ready = 1'b0;
  logic [CNT_W-1:0]              rsp_count;
  logic [ID_W-1:0]               rsp_id;
  logic                          busy;

  popcount_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_count(rsp_count),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int m_rr  = 0;   // model round-robin pointer

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Model and stimulus helpers (no comparisons here).
  // ---------------------------------------------------------------------------
  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return DATA_WIDTH'({$urandom, $urandom});
    endcase
  endfunction

  // Waits (bounded) for a grant. Returns the observed grant index and vector,
  // the model's expected winner and the grant cycle; the granted requester
  // then drops req_valid in the following cycle.
  task automatic await_grant(output int gid, output logic [NUM_REQ-1:0] rdy,
                             output int exp_g, output int gcyc);
    logic [NUM_REQ-1:0] vmask;
    gid   = -1;
    rdy   = '0;
    gcyc  = -1;
    vmask = '0;
    for (int i = 0; i < 40 && gcyc < 0; i++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        rdy   = req_ready;
        vmask = req_valid;
        gcyc  = cyc;
        for (int b = NUM_REQ - 1; b >= 0; b--) if (req_ready[b] === 1'b1) gid = b;
      end
    end
    if (gcyc < 0) vmask = req_valid;
    exp_g = model_pick(vmask);
    if (exp_g >= 0) m_rr = (exp_g + 1) % NUM_REQ;
    if (gcyc >= 0) begin
      @(posedge clk); #1;
      if (gid >= 0) req_valid[gid] = 1'b0;
    end
  endtask

  task automatic await_rsp(output int rcyc, output logic [CNT_W-1:0] cnt,
                           output logic [ID_W-1:0] id);
    rcyc = -1;
    cnt  = '0;
    id   = '0;
    for (int i = 0; i < 40 && rcyc < 0; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rcyc = cyc;
        cnt  = rsp_count;
        id   = rsp_id;
      end
    end
  endtask

  task automatic set_op(input int r, input logic [DATA_WIDTH-1:0] v);
    req_data[r*DATA_WIDTH +: DATA_WIDTH] = v;
    req_valid[r] = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    resetn = 1'b0;
    m_rr   = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = NUM_REQ'($urandom);
      for (int r = 0; r < NUM_REQ; r++) req_data[r*DATA_WIDTH +: DATA_WIDTH] = rand_operand();
      rsp_ready = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_count, rsp_id, busy} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold: ready=%b valid=%b count=%0d id=%0d busy=%b, required all 0",
                 req_ready, rsp_valid, rsp_count, rsp_id, busy);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    resetn    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_count, rsp_id, busy} !== '0) begin
        n_bad++;
        $display("FAIL reset_release: ready=%b valid=%b count=%0d id=%0d busy=%b, required all 0",
                 req_ready, rsp_valid, rsp_count, rsp_id, busy);
      end
    end
  endtask

  task automatic test_single();
    logic [DATA_WIDTH-1:0] ops [3];
    int                    exps [3];
    int gid, exp_g, gcyc, rcyc, set_cyc;
    logic [NUM_REQ-1:0] rdy;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    id;
    ops[0] = 64'hFFFF_FFFF_FFFF_FFFF; exps[0] = 64;
    ops[1] = 64'h0;                   exps[1] = 0;
    ops[2] = 64'hAAAA_AAAA_AAAA_AAAA; exps[2] = 32;
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      set_op(0, ops[t]);
      set_cyc = cyc;
      await_grant(gid, rdy, exp_g, gcyc);
      n_cmp++;
      if (rdy !== 4'b0001 || gcyc != set_cyc || exp_g != 0) begin
        n_bad++;
        $display("FAIL single_grant[%0d]: ready=%b at cycle %0d, required 0001 at cycle %0d",
                 t, rdy, gcyc, set_cyc);
      end
      await_rsp(rcyc, cnt, id);
      n_cmp++;
      if (rcyc - gcyc != LAT || cnt !== CNT_W'(exps[t]) || id !== ID_W'(0)) begin
        n_bad++;
        $display("FAIL single_rsp[%0d]: latency=%0d count=%0d id=%0d, required latency=%0d count=%0d id=0",
                 t, rcyc - gcyc, cnt, id, LAT, exps[t]);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL single_done[%0d]: busy=%b rsp_valid=%b, required 0/0 after handshake",
                 t, busy, rsp_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    int gid, exp_g, gcyc, rcyc, prev_g;
    logic [NUM_REQ-1:0] rdy;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    id;
    int order [2];
    int ecnt;
    @(posedge clk); #1;
    resetn = 1'b0;
    m_rr   = 0;
    rsp_ready = 1'b1;
    set_op(0, 64'h1); set_op(1, 64'h3); set_op(2, 64'h7); set_op(3, 64'hF);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    prev_g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      await_grant(gid, rdy, exp_g, gcyc);
      n_cmp++;
      if (gid != k || exp_g != k || rdy !== NUM_REQ'(1 << k) || (k > 0 && gcyc - prev_g != NUM_CHUNKS + 2)) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: ready=%b spacing=%0d, required ready=%b spacing=%0d",
                 k, rdy, gcyc - prev_g, NUM_REQ'(1 << k), NUM_CHUNKS + 2);
      end
      prev_g = gcyc;
      await_rsp(rcyc, cnt, id);
      n_cmp++;
      if (rcyc - gcyc != LAT || cnt !== CNT_W'(k + 1) || id !== ID_W'(k)) begin
        n_bad++;
        $display("FAIL rr_rsp[%0d]: latency=%0d count=%0d id=%0d, required latency=%0d count=%0d id=%0d",
                 k, rcyc - gcyc, cnt, id, LAT, k + 1, k);
      end
    end
    // Only requesters 0 and 2: pointer is back at 0, so 0 then 2.
    @(posedge clk); #1;
    set_op(0, rand_operand());
    set_op(2, rand_operand());
    order[0] = 0; order[1] = 2;
    for (int k = 0; k < 2; k++) begin
      ecnt = $countones(req_data[order[k]*DATA_WIDTH +: DATA_WIDTH]);
      await_grant(gid, rdy, exp_g, gcyc);
      n_cmp++;
      if (gid != order[k] || exp_g != order[k]) begin
        n_bad++;
        $display("FAIL rr_pair[%0d]: granted %0d, required %0d (model %0d)", k, gid, order[k], exp_g);
      end
      await_rsp(rcyc, cnt, id);
      n_cmp++;
      if (cnt !== CNT_W'(ecnt) || id !== ID_W'(order[k])) begin
        n_bad++;
        $display("FAIL rr_pair_rsp[%0d]: count=%0d id=%0d, required count=%0d id=%0d",
                 k, cnt, id, ecnt, order[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int gid, exp_g, gcyc, rcyc, h, ecnt;
    logic [NUM_REQ-1:0] rdy;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    id;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_op(1, 64'h00FF_0000_0000_0001);
    await_grant(gid, rdy, exp_g, gcyc);
    n_cmp++;
    if (gid != 1 || exp_g != 1) begin
      n_bad++;
      $display("FAIL bp_grant: granted %0d, required 1 (model %0d)", gid, exp_g);
    end
    set_op(0, rand_operand());
    ecnt = $countones(req_data[0 +: DATA_WIDTH]);
    await_rsp(rcyc, cnt, id);
    n_cmp++;
    if (rcyc - gcyc != LAT || cnt !== CNT_W'(9) || id !== ID_W'(1)) begin
      n_bad++;
      $display("FAIL bp_rsp: latency=%0d count=%0d id=%0d, required latency=%0d count=9 id=1",
               rcyc - gcyc, cnt, id, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_count !== CNT_W'(9) || rsp_id !== ID_W'(1) ||
          req_ready !== '0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b count=%0d id=%0d ready=%b busy=%b, required 1/9/1/0000/1",
                 i, rsp_valid, rsp_count, rsp_id, req_ready, busy);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    h = cyc;
    @(negedge clk);
    await_grant(gid, rdy, exp_g, gcyc);
    n_cmp++;
    if (gid != 0 || exp_g != 0 || gcyc != h + 1) begin
      n_bad++;
      $display("FAIL bp_release: granted %0d at cycle %0d, required 0 at cycle %0d", gid, gcyc, h + 1);
    end
    await_rsp(rcyc, cnt, id);
    n_cmp++;
    if (cnt !== CNT_W'(ecnt) || id !== ID_W'(0)) begin
      n_bad++;
      $display("FAIL bp_next_rsp: count=%0d id=%0d, required count=%0d id=0", cnt, id, ecnt);
    end
  endtask

  task automatic test_late_data();
    int gid, exp_g, gcyc, rcyc, ecnt;
    logic [NUM_REQ-1:0]    rdy;
    logic [CNT_W-1:0]      cnt;
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] d;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    d = DATA_WIDTH'({$urandom, $urandom}) & ~DATA_WIDTH'(1);
    ecnt = $countones(d);
    set_op(3, d);
    await_grant(gid, rdy, exp_g, gcyc);
    req_data[3*DATA_WIDTH +: DATA_WIDTH] = '1;
    await_rsp(rcyc, cnt, id);
    n_cmp++;
    if (gid != 3 || cnt !== CNT_W'(ecnt) || id !== ID_W'(3)) begin
      n_bad++;
      $display("FAIL late_data: grant=%0d count=%0d id=%0d, required grant=3 count=%0d id=3",
               gid, cnt, id, ecnt);
    end
  endtask

  task automatic test_reset_mid_count();
    int gid, exp_g, gcyc, rcyc, rel, ecnt2, ecnt3;
    logic [NUM_REQ-1:0] rdy;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    id;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_op(2, '1);
    await_grant(gid, rdy, exp_g, gcyc);
    @(posedge clk); #1;
    resetn = 1'b0;
    m_rr   = 0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, busy} !== '0) begin
      n_bad++;
      $display("FAIL midreset_clear: ready=%b valid=%b busy=%b, required all 0", req_ready, rsp_valid, busy);
    end
    set_op(2, rand_operand());
    set_op(3, rand_operand());
    ecnt2 = $countones(req_data[2*DATA_WIDTH +: DATA_WIDTH]);
    ecnt3 = $countones(req_data[3*DATA_WIDTH +: DATA_WIDTH]);
    @(posedge clk); #1;
    resetn = 1'b1;
    rel    = cyc;
    await_grant(gid, rdy, exp_g, gcyc);
    n_cmp++;
    if (gid != 2 || exp_g != 2 || gcyc != rel) begin
      n_bad++;
      $display("FAIL midreset_grant: granted %0d at cycle %0d, required 2 at cycle %0d", gid, gcyc, rel);
    end
    await_rsp(rcyc, cnt, id);
    n_cmp++;
    if (rcyc - gcyc != LAT || cnt !== CNT_W'(ecnt2) || id !== ID_W'(2)) begin
      n_bad++;
      $display("FAIL midreset_rsp: latency=%0d count=%0d id=%0d, required latency=%0d count=%0d id=2",
               rcyc - gcyc, cnt, id, LAT, ecnt2);
    end
    await_grant(gid, rdy, exp_g, gcyc);
    await_rsp(rcyc, cnt, id);
    n_cmp++;
    if (gid != 3 || cnt !== CNT_W'(ecnt3) || id !== ID_W'(3)) begin
      n_bad++;
      $display("FAIL midreset_next: grant=%0d count=%0d id=%0d, required grant=3 count=%0d id=3",
               gid, cnt, id, ecnt3);
    end
  endtask

  task automatic test_random();
    int gid, exp_g, gcyc, rcyc, ecnt, hold;
    logic [NUM_REQ-1:0] rdy;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    id;
    @(posedge clk); #1;
    for (int n = 0; n < 30; n++) begin
      rsp_ready = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!req_valid[r] && $urandom_range(0, 1) == 1) set_op(r, rand_operand());
      end
      if (req_valid == '0) set_op($urandom_range(0, NUM_REQ - 1), rand_operand());
      await_grant(gid, rdy, exp_g, gcyc);
      ecnt = (exp_g >= 0) ? $countones(req_data[exp_g*DATA_WIDTH +: DATA_WIDTH]) : -1;
      n_cmp++;
      if (gid != exp_g || exp_g < 0 || rdy !== NUM_REQ'(1 << exp_g)) begin
        n_bad++;
        $display("FAIL rand_grant[%0d]: ready=%b, required winner %0d", n, rdy, exp_g);
      end
      if (exp_g >= 0 && $urandom_range(0, 1) == 1) begin
        req_data[exp_g*DATA_WIDTH +: DATA_WIDTH] = rand_operand();
      end
      await_rsp(rcyc, cnt, id);
      n_cmp++;
      if (rcyc - gcyc != LAT || cnt !== CNT_W'(ecnt) || id !== ID_W'(exp_g)) begin
        n_bad++;
        $display("FAIL rand_rsp[%0d]: latency=%0d count=%0d id=%0d, required latency=%0d count=%0d id=%0d",
                 n, rcyc - gcyc, cnt, id, LAT, ecnt, exp_g);
      end
      hold = $urandom_range(0, 3);
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_count !== CNT_W'(ecnt) || rsp_id !== ID_W'(exp_g)) begin
          n_bad++;
          $display("FAIL rand_hold[%0d]: valid=%b count=%0d id=%0d, required 1/%0d/%0d",
                   n, rsp_valid, rsp_count, rsp_id, ecnt, exp_g);
        end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_late_data();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
